// File: rtl/transmitter_pkg.sv
// Constants shared by the transmitter and receiver: data bus width and
// handshake FSM state encodings.
package transmitter_pkg;

    localparam int DATA_MSB = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ_HI = 2'b01,
        REQ_LO = 2'b10
    } tx_state_e;

endpackage

// File: rtl/transmitter_dff.sv
// Single reset-to-zero flop used as one stage of the ack synchronizer.
module dff (
    output logic q,
    input  logic d,
    input  logic clk,
    input  logic reset
);

    // plain flop, cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/transmitter.sv
// Four-phase request/acknowledge transmitter toward another clock domain.
// Optional ack timeout with sticky err is enabled by defining TX_ACK_TIMEOUT_EN.
module transmitter
    import transmitter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                v,
    input  logic [DATA_MSB:0]   input_tx,
    input  logic                ack,
    output logic                req,
    output logic [DATA_MSB:0]   output_tx,
    output logic                ready,
    output logic                done,
    output logic                err
);

    logic              ack_s1;
    logic              ack_s2;
    tx_state_e         state_r;
    tx_state_e         state_n;
    logic              req_r;
    logic              req_n;
    logic              done_r;
    logic              done_n;
    logic              ready_r;
    logic              err_r;
    logic              err_n;
    logic              timeout_s;
    logic [DATA_MSB:0] data_r;
    logic [DATA_MSB:0] data_n;

    dff u_ack_sync1 (.q(ack_s1), .d(ack),    .clk(clk), .reset(reset));
    dff u_ack_sync2 (.q(ack_s2), .d(ack_s1), .clk(clk), .reset(reset));

`ifdef TX_ACK_TIMEOUT_EN
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    assign timeout_s = (state_r != IDLE) && (cnt_r == CNT_LAST);

    // cycles spent waiting in the current handshake phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_n != state_r) || (state_r == IDLE)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // next state and next register values of the handshake FSM
    always_comb begin
        state_n = state_r;
        req_n   = req_r;
        data_n  = data_r;
        done_n  = 1'b0;
        err_n   = err_r;
        case (state_r)
            IDLE: begin
                // the done cycle is a dead cycle so transfers never abut
                if (v && !done_r) begin
                    data_n  = input_tx;
                    req_n   = 1'b1;
                    state_n = REQ_HI;
                end else begin
                    state_n = IDLE;
                end
            end
            REQ_HI: begin
                if (ack_s2) begin
                    req_n   = 1'b0;
                    state_n = REQ_LO;
                end else if (timeout_s) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = REQ_HI;
                end
            end
            REQ_LO: begin
                if (!ack_s2) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (timeout_s) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = REQ_LO;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // state register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            data_r  <= {(DATA_MSB+1){1'b0}};
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            req_r   <= req_n;
            data_r  <= data_n;
            done_r  <= done_n;
            ready_r <= (state_n == IDLE);
            err_r   <= err_n;
        end
    end

    assign req       = req_r;
    assign output_tx = data_r;
    assign ready     = ready_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
